fifo_write: RTL and testbench
=============================

# fifo_write

Byte-serialising FIFO writer: on a start request it snapshots a flat vector of `FIFO_NUM` bytes and pushes them one byte per cycle into a byte-wide FIFO, honouring the FIFO's full flag. It is the write-side counterpart of the existing byte-gathering FIFO reader. It uses the same `fs`/`fd` start/done handshake, so a controller can chain write and read phases through the same FIFO.

## Interface
- `FIFO_NUM`, default 12'd8, number of bytes per transfer; legal range 1..4095.

- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  reset; synchronous, active-low (asserted when 0, sampled on posedge `clk`).
- `err`  input  1  abort request; sampled on posedge.
- `data`  input  [0:FIFO_NUM*8-1]  payload; byte k = `data[k*8 +: 8]`; byte 0 (`data[0:7]`) is written first.
- `fifo_full`  input  1  FIFO full flag; while 1, no write is issued.
- `dout`  output  8  byte presented to the FIFO write port.
- `fifo_txen`  output  1  FIFO write enable; a write occurs at every posedge where it is 1.
- `fs`  input  1  start request, level.
- `fd`  output  1  done flag, level.

## Operation
- Internal registers: `state` (IDLE, LOAD, WORK, LAST), 12-bit byte counter `cnt`, and a shadow copy `buf` of `data`.
- Reset (`rst`=0 at posedge): state=IDLE, cnt=0, buf=0.
  - Outputs after reset: `dout`=8'h00, `fifo_txen`=0, `fd`=0.
  - Reset overrides all other inputs in any state, mid-transfer included; a partial transfer is abandoned.
- IDLE:
  - `fs`=1 and `err`=0 → LOAD; `buf` <= `data` on that edge.
  - Otherwise stay in IDLE.
- LOAD: one cycle; cnt <= 0; → WORK. `err`=1 → IDLE instead.
- WORK:
  - `fifo_txen` = !`fifo_full` (combinational); `dout` = `buf[cnt*8 +: 8]` (combinational mux of registers).
  - Posedge with `fifo_txen`=1: cnt <= cnt+1. If cnt == FIFO_NUM-1 → LAST and cnt <= 0.
  - Posedge with `fifo_full`=1: hold state and cnt. No byte is skipped or duplicated.
- LAST: `fd`=1, `fifo_txen`=0; `fs`=0 → IDLE, otherwise stay in LAST.
- `err`=1 at a posedge in LOAD, WORK or LAST → IDLE, cnt <= 0, `fd` not asserted. Bytes already written stay in the FIFO. In IDLE, `err`=1 blocks a start.
- `fd` = (state==LAST), decoded from the registered state, so it is glitch-free.
- `fifo_txen` is 0 in every state other than WORK.
- `dout` outside WORK shows `buf[cnt*8 +: 8]` with cnt=0; it is don't-care to the FIFO.
- `data` changes after the start edge have no effect on the transfer in progress.
- Counter width is 12 bits; it never wraps because the terminal compare is FIFO_NUM-1.

## Timing
- E0: posedge where IDLE samples `fs`=1. After E0, state is LOAD.
- E1: next posedge; after it, state is WORK and byte 0 is on `dout` with `fifo_txen`=1 (if not full).
- No backpressure: byte k is written at edge E(2+k). The last write is at E(FIFO_NUM+1), and the same edge moves the state to LAST. `fd` is high from E(FIFO_NUM+1) onward.
- Each cycle with `fifo_full`=1 during WORK adds exactly one cycle of latency.
- `fs` dropping during LOAD or WORK is ignored; the transfer completes. Entering LAST with `fs`=0 gives a 1-cycle `fd` pulse, then IDLE.
- Back-to-back transfers: from LAST, drop `fs` → IDLE; the earliest restart is the next posedge after IDLE is entered.
- FIFO_NUM=1: exactly one write, at E2; LAST after E2.

## Test plan
- Basic transfer: FIFO_NUM=8, `data`=64'h11223344_55667788, `fs` held high, `fifo_full`=0 → writes 11,22,33,44,55,66,77,88 at E2..E9; `fifo_txen` high for exactly 8 cycles; `fd` rises after E9. Dropping `fs` → IDLE on the next edge with `fd`=0.
- Backpressure: as above, with `fifo_full`=1 for 3 cycles while byte 33 is presented → 33 is written once, after full deasserts; the sequence is unchanged; `fd` is 3 cycles later (after E12).
- Snapshot: change `data` to all 8'hFF one cycle after E0 → the FIFO still receives 11..88.
- Abort: assert `err` for one cycle after 4 bytes have been written → next state IDLE, `fifo_txen`=0, `fd` never asserts; a new `fs` then restarts from byte 11.
- Reset mid-transfer: `rst`=0 during WORK → at that edge `fifo_txen`=0, `fd`=0, `dout`=00; with `rst` back at 1 and `fs` held high, a fresh transfer starts at byte 0.
- Edge cases: FIFO_NUM=1, `data`=8'hA5 → a single write of A5 at E2, then LAST. `fs` pulsed for 1 cycle only → the full transfer completes, followed by a 1-cycle `fd` pulse.

Source files
------------

// File: rtl/fifo_write.sv
// Byte-serialising FIFO writer: snapshots FIFO_NUM bytes on a start request and
// pushes them one per cycle into a byte-wide FIFO, stalling while the FIFO is full.
module fifo_write #(
  parameter logic [11:0] FIFO_NUM = 12'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  err,
  input  logic [0:FIFO_NUM*8-1] data,
  input  logic                  fifo_full,
  output logic [7:0]            dout,
  output logic                  fifo_txen,
  input  logic                  fs,
  output logic                  fd
);

  localparam int BITS  = int'(FIFO_NUM) * 8;
  localparam int IDX_W = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, LOAD, WORK, LAST} state_t;

  state_t          state, state_nxt;
  logic [11:0]     cnt, cnt_nxt;
  logic [0:BITS-1] shadow;
  logic            load;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) shadow <= data;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (fs && !err) begin
          state_nxt = LOAD;
          load      = 1'b1;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = err ? IDLE : WORK;
      end
      WORK: begin
        if (err) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!fifo_full) begin
          // The terminal compare keeps the 12-bit counter from ever wrapping.
          if (cnt == FIFO_NUM - 12'd1) begin
            state_nxt = LAST;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 12'd1;
          end
        end
      end
      LAST: begin
        cnt_nxt = '0;
        if (err || !fs) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Byte k sits at shadow[k*8 +: 8]; byte 0 is the leftmost byte of data.
  assign idx       = IDX_W'({cnt, 3'b000});
  assign dout      = shadow[idx +: 8];
  assign fifo_txen = (state == WORK) && !fifo_full;
  assign fd        = (state == LAST);

endmodule

// File: tb/tb_fifo_write.sv
// Directed table-driven bench for fifo_write: an 8-byte instance runs the vector
// table, a 1-byte instance covers the single-byte transfer.
module tb_fifo_write;

  localparam logic [63:0] D = 64'h1122334455667788;
  localparam logic [63:0] F = 64'hFFFFFFFFFFFFFFFF;

  typedef struct {
    logic        rst;
    logic        fs;
    logic        err;
    logic        full;
    logic [63:0] data;
    logic        txen;
    logic        fd;
    logic [7:0]  dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err8, fs8, full8, txen8, fd8;
  logic [0:63] data8;
  logic [7:0]  dout8;
  logic        err1, fs1, full1, txen1, fd1;
  logic [0:7]  data1;
  logic [7:0]  dout1;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  fifo_write #(.FIFO_NUM(12'd8)) u8 (
    .clk(clk), .rst(rst), .err(err8), .data(data8), .fifo_full(full8),
    .dout(dout8), .fifo_txen(txen8), .fs(fs8), .fd(fd8)
  );

  fifo_write #(.FIFO_NUM(12'd1)) u1 (
    .clk(clk), .rst(rst), .err(err1), .data(data1), .fifo_full(full1),
    .dout(dout1), .fifo_txen(txen1), .fs(fs1), .fd(fd1)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic f, input logic e, input logic fl,
                     input logic [63:0] d, input logic tx, input logic done,
                     input logic [7:0] dv);
    vec_t v;
    v.rst = r; v.fs = f; v.err = e; v.full = fl; v.data = d;
    v.txen = tx; v.fd = done; v.dout = dv;
    vecs.push_back(v);
  endtask

  task automatic add_work(input int first, input int last_k, input logic f,
                          input logic [63:0] d);
    for (int k = first; k <= last_k; k++)
      add(1'b1, f, 1'b0, 1'b0, d, 1'b1, 1'b0, 8'(8'h11 * (k + 1)));
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input int idx, input logic got,
                         input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %b, expected %b", nm, idx, got, exp);
    end
  endtask

  initial begin
    // basic transfer, fs held through LAST for one cycle
    add(1, 1, 0, 0, D, 0, 0, 8'h00);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 7, 1'b1, D);
    add(1, 1, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    // backpressure: full for 3 cycles while byte 33 is presented
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 1, 1'b1, D);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, D, 0, 0, 8'h33);
    add_work(2, 7, 1'b1, D);
    add(1, 0, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    // snapshot: data goes to all FF right after the start edge
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, F, 0, 0, 8'h11);
    add_work(0, 7, 1'b1, F);
    add(1, 0, 0, 0, F, 0, 1, 8'h11);
    add(1, 0, 0, 0, F, 0, 0, 8'h11);
    // err in IDLE blocks a start
    add(1, 1, 1, 0, F, 0, 0, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    // abort after four bytes, then a clean restart
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 3, 1'b1, D);
    add(1, 0, 1, 0, D, 1, 0, 8'h55);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 7, 1'b1, D);
    add(1, 0, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    // reset mid-transfer, then a fresh transfer with fs held
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 2, 1'b1, D);
    add(0, 1, 0, 0, D, 1, 0, 8'h44);
    add(1, 1, 0, 0, D, 0, 0, 8'h00);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 7, 1'b1, D);
    add(1, 1, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    // one-cycle fs pulse: transfer completes, fd pulses for one cycle
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 7, 1'b0, D);
    add(1, 0, 0, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);
    // err in LAST returns to IDLE
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add(1, 1, 0, 0, D, 0, 0, 8'h11);
    add_work(0, 7, 1'b1, D);
    add(1, 1, 1, 0, D, 0, 1, 8'h11);
    add(1, 0, 0, 0, D, 0, 0, 8'h11);

    rst = 1'b0;
    fs8 = 1'b0; err8 = 1'b0; full8 = 1'b0; data8 = '0;
    fs1 = 1'b0; err1 = 1'b0; full1 = 1'b0; data1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_bit("reset_txen", -1, txen8, 1'b0);
    chk_bit("reset_fd", -1, fd8, 1'b0);
    chk("reset_dout", -1, dout8, 8'h00);
    chk_bit("reset_txen_n1", -1, txen1, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      fs8   = vecs[i].fs;
      err8  = vecs[i].err;
      full8 = vecs[i].full;
      data8 = vecs[i].data;
      #1;
      chk_bit("txen", i, txen8, vecs[i].txen);
      chk_bit("fd", i, fd8, vecs[i].fd);
      chk("dout", i, dout8, vecs[i].dout);
    end

    // single-byte instance: one write at E2, then LAST
    @(negedge clk);
    fs8 = 1'b0; err8 = 1'b0; full8 = 1'b0;
    fs1 = 1'b1; data1 = 8'hA5;
    #1;
    chk_bit("n1_idle_txen", 0, txen1, 1'b0);
    chk("n1_idle_dout", 0, dout1, 8'h00);
    @(negedge clk); #1;
    chk_bit("n1_load_txen", 1, txen1, 1'b0);
    chk("n1_load_dout", 1, dout1, 8'hA5);
    @(negedge clk); #1;
    chk_bit("n1_work_txen", 2, txen1, 1'b1);
    chk("n1_work_dout", 2, dout1, 8'hA5);
    chk_bit("n1_work_fd", 2, fd1, 1'b0);
    @(negedge clk); #1;
    chk_bit("n1_last_fd", 3, fd1, 1'b1);
    chk_bit("n1_last_txen", 3, txen1, 1'b0);
    fs1 = 1'b0;
    @(negedge clk); #1;
    chk_bit("n1_idle2_fd", 4, fd1, 1'b0);
    chk_bit("n1_idle2_txen", 4, txen1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
